mod_counter_updown: RTL and testbench

- Parametrised up/down modulo-(final_value+1) counter with synchronous clear, parallel load, three terminal-count modes (wrap, saturate, one-shot) and a cascade carry.
- Successor to the team's basic modulo counter: adds direction control, load, mode selection and registered event flags.
- Used as the timebase and divider primitive in timers, baud generators and multi-digit counter chains.

---
 rtl/mod_counter_pkg.sv | 10 +
 rtl/mod_counter_next.sv | 53 +++++
 rtl/mod_counter_updown.sv | 68 ++++++
 tb/tb_mod_counter_updown.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants for the up/down modulo counter family.
package mod_counter_pkg;

  // Terminal-count behaviour selected by the 2-bit mode input
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: step, terminal handling and out-of-range recovery.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] q,
  input  logic         up_down,
  input  logic [1:0]   mode,
  input  logic [N-1:0] final_value,
  input  logic         halted,
  output logic [N-1:0] q_next,
  output logic         at_term,
  output logic         wrap_event,
  output logic         set_halted
);

  logic [N-1:0] terminal;
  logic         out_of_range;

  assign terminal     = up_down ? final_value : '0;
  assign at_term      = (q == terminal);
  assign out_of_range = (q > final_value);

  // Next value if this edge counts; a loaded value above the range re-enters at the far end
  always_comb begin
    q_next     = q;
    wrap_event = 1'b0;
    set_halted = 1'b0;
    if (!halted && (mode != MODE_HOLD)) begin
      if (out_of_range) begin
        if (up_down) begin
          q_next     = '0;
          wrap_event = (mode == MODE_WRAP);
        end else begin
          q_next = final_value;
        end
      end else if (at_term) begin
        unique case (mode)
          MODE_WRAP: begin
            q_next     = up_down ? '0 : final_value;
            wrap_event = 1'b1;
          end
          MODE_ONESHOT: set_halted = 1'b1;
          default: ;
        endcase
      end else begin
        q_next = up_down ? (q + N'(1)) : (q - N'(1));
      end
    end
  end

endmodule

// File: rtl/mod_counter_updown.sv
// Up/down modulo counter with clear, load, wrap/saturate/one-shot modes and cascade carry.
module mod_counter_updown
  import mod_counter_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         up_down,
  input  logic [1:0]   mode,
  input  logic [N-1:0] final_value,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         wrap_pulse,
  output logic         halted
);

  logic [N-1:0] q_next;
  logic         at_term;
  logic         wrap_event;
  logic         set_halted;
  logic         count_en;

  mod_counter_next #(.N(N)) u_next (
    .q           (Q),
    .up_down     (up_down),
    .mode        (mode),
    .final_value (final_value),
    .halted      (halted),
    .q_next      (q_next),
    .at_term     (at_term),
    .wrap_event  (wrap_event),
    .set_halted  (set_halted)
  );

  assign count_en = enable & ~halted & (mode != MODE_HOLD);

  // Zero-latency carry so the next stage can use it directly as its enable
  assign tc = enable & at_term & (mode == MODE_WRAP) & ~halted;

  // Count state with clear > load > count priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q          <= '0;
      wrap_pulse <= 1'b0;
      halted     <= 1'b0;
    end else if (clear) begin
      Q          <= '0;
      wrap_pulse <= 1'b0;
      halted     <= 1'b0;
    end else if (load) begin
      Q          <= load_value;
      wrap_pulse <= 1'b0;
      halted     <= 1'b0;
    end else if (count_en) begin
      Q          <= q_next;
      wrap_pulse <= wrap_event;
      halted     <= set_halted;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter_updown.sv
// Scenario bench for mod_counter_updown (N=4) including a two-stage cascade.
module tb_mod_counter_updown;

  typedef struct packed {
    logic [3:0] q;
    logic       wp;
    logic       h;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, clear, load, up_down;
  logic [3:0] load_value, final_value;
  logic [1:0] mode;
  logic [3:0] q0, q1;
  logic       tc0, tc1, wp0, wp1, h0, h1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic obs_tc;
  int   m_q, m_wp, m_h;

  always #5 clk = ~clk;

  mod_counter_updown #(.N(4)) u_stage0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down), .mode(mode), .final_value(final_value),
    .Q(q0), .tc(tc0), .wrap_pulse(wp0), .halted(h0)
  );

  mod_counter_updown #(.N(4)) u_stage1 (
    .clk(clk), .reset_n(reset_n), .enable(tc0), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down), .mode(mode), .final_value(final_value),
    .Q(q1), .tc(tc1), .wrap_pulse(wp1), .halted(h1)
  );

  // Reference behaviour of one counter across one edge
  task automatic model_edge(input logic en, input logic clr, input logic ld, input logic [3:0] lv,
                            input logic ud, input logic [1:0] md, input logic [3:0] fv);
    int term;
    term = ud ? int'(fv) : 0;
    if (clr) begin
      m_q = 0; m_wp = 0; m_h = 0;
    end else if (ld) begin
      m_q = int'(lv); m_wp = 0; m_h = 0;
    end else if (en && m_h == 0 && md != 2'b11) begin
      m_wp = 0;
      if (m_q > int'(fv)) begin
        if (ud) begin m_q = 0; m_wp = (md == 2'b00) ? 1 : 0; end
        else m_q = int'(fv);
      end else if (m_q == term) begin
        if (md == 2'b00) begin m_q = ud ? 0 : int'(fv); m_wp = 1; end
        else if (md == 2'b10) m_h = 1;
      end else begin
        m_q = ud ? (m_q + 1) % 16 : (m_q + 15) % 16;
      end
    end else begin
      m_wp = 0;
    end
  endtask

  // Apply inputs for one cycle, queue the expected result, advance past the edge
  task automatic drive(input logic en, input logic clr, input logic ld, input logic [3:0] lv,
                       input logic ud, input logic [1:0] md, input logic [3:0] fv);
    exp_t e;
    enable = en; clear = clr; load = ld; load_value = lv;
    up_down = ud; mode = md; final_value = fv;
    #1;
    obs_tc = tc0;
    e.tc = en && m_h == 0 && md == 2'b00 && m_q == (ud ? int'(fv) : 0);
    model_edge(en, clr, ld, lv, ud, md, fv);
    e.q  = 4'(m_q);
    e.wp = (m_wp != 0);
    e.h  = (m_h != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; load_value = 4'd0;
    up_down = 1'b1; mode = 2'b00; final_value = 4'd9;
    m_q = 0; m_wp = 0; m_h = 0;
    #12;
    checks++; if (q0 !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q0); end
    checks++; if (wp0 !== 1'b0) begin failures++; $display("FAIL reset_wp got=%b exp=0", wp0); end
    checks++; if (h0 !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", h0); end
    reset_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    int pulses = 0;
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 4'd9);
      e = sb.pop_front();
      checks++; if (obs_tc !== e.tc) begin failures++; $display("FAIL wrap_up_tc cyc=%0d got=%b exp=%b", i, obs_tc, e.tc); end
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL wrap_up_q cyc=%0d got=%0d exp=%0d", i, q0, e.q); end
      checks++; if (wp0 !== e.wp) begin failures++; $display("FAIL wrap_up_wp cyc=%0d got=%b exp=%b", i, wp0, e.wp); end
      checks++; if (h0 !== e.h) begin failures++; $display("FAIL wrap_up_halted cyc=%0d got=%b exp=%b", i, h0, e.h); end
      if (wp0 === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL wrap_up_pulse_count got=%0d exp=2", pulses); end
  endtask

  task automatic test_wrap_down();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i == 0, 1'b0, 4'd0, 1'b0, 2'b00, 4'd5);
      e = sb.pop_front();
      checks++; if (obs_tc !== e.tc) begin failures++; $display("FAIL wrap_down_tc cyc=%0d got=%b exp=%b", i, obs_tc, e.tc); end
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL wrap_down_q cyc=%0d got=%0d exp=%0d", i, q0, e.q); end
      checks++; if (wp0 !== e.wp) begin failures++; $display("FAIL wrap_down_wp cyc=%0d got=%b exp=%b", i, wp0, e.wp); end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, i == 0, 1'b0, 4'd0, i < 6, 2'b01, 4'd3);
      e = sb.pop_front();
      checks++; if (obs_tc !== e.tc) begin failures++; $display("FAIL sat_tc cyc=%0d got=%b exp=%b", i, obs_tc, e.tc); end
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL sat_q cyc=%0d got=%0d exp=%0d", i, q0, e.q); end
      checks++; if (wp0 !== 1'b0) begin failures++; $display("FAIL sat_wp cyc=%0d got=%b exp=0", i, wp0); end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i == 0, i == 6, 4'd1, 1'b1, 2'b10, 4'd2);
      e = sb.pop_front();
      checks++; if (obs_tc !== e.tc) begin failures++; $display("FAIL oneshot_tc cyc=%0d got=%b exp=%b", i, obs_tc, e.tc); end
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL oneshot_q cyc=%0d got=%0d exp=%0d", i, q0, e.q); end
      checks++; if (h0 !== e.h) begin failures++; $display("FAIL oneshot_halted cyc=%0d got=%b exp=%b", i, h0, e.h); end
      if (i == 6) begin
        checks++; if (q0 !== 4'd1 || h0 !== 1'b0) begin failures++; $display("FAIL oneshot_load got q=%0d h=%b exp q=1 h=0", q0, h0); end
      end
    end
  endtask

  // Priority, out-of-range recovery, final_value=0 and hold mode
  task automatic test_priority();
    exp_t e;
    logic [3:0] fv;
    for (int i = 0; i < 14; i++) begin
      fv = (i >= 5 && i < 10) ? 4'd0 : 4'd9;
      case (i)
        0:       drive(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 2'b00, fv);
        1:       drive(1'b1, 1'b0, 1'b1, 4'd12, 1'b1, 2'b00, fv);
        3:       drive(1'b1, 1'b0, 1'b1, 4'd13, 1'b0, 2'b00, fv);
        4:       drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, fv);
        7:       drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, fv);
        10:      drive(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 2'b11, fv);
        11, 12:  drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b11, fv);
        default: drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, fv);
      endcase
      e = sb.pop_front();
      checks++; if (obs_tc !== e.tc) begin failures++; $display("FAIL prio_tc cyc=%0d got=%b exp=%b", i, obs_tc, e.tc); end
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL prio_q cyc=%0d got=%0d exp=%0d", i, q0, e.q); end
      checks++; if (wp0 !== e.wp) begin failures++; $display("FAIL prio_wp cyc=%0d got=%b exp=%b", i, wp0, e.wp); end
    end
  endtask

  task automatic test_cascade();
    exp_t e;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 2'b00, 4'd9);
    e = sb.pop_front();
    checks++; if (q0 !== e.q || q1 !== 4'd0) begin failures++; $display("FAIL cascade_clear got=%0d/%0d exp=%0d/0", q0, q1, e.q); end
    for (int k = 1; k <= 137; k++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 4'd9);
      e = sb.pop_front();
      checks++; if (q0 !== e.q) begin failures++; $display("FAIL cascade_q0 k=%0d got=%0d exp=%0d", k, q0, e.q); end
      checks++; if (q1 !== 4'((k / 10) % 10)) begin failures++; $display("FAIL cascade_q1 k=%0d got=%0d exp=%0d", k, q1, (k / 10) % 10); end
      if (k == 100) begin
        checks++; if (q0 !== 4'd0 || q1 !== 4'd0) begin failures++; $display("FAIL cascade_100 got=%0d/%0d exp=0/0", q0, q1); end
      end
    end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (q0 !== 4'd0 || q1 !== 4'd0) begin failures++; $display("FAIL async_reset_q got=%0d/%0d exp=0/0", q0, q1); end
    checks++; if ({wp0, h0, wp1, h1, tc1} !== 5'b0) begin failures++; $display("FAIL async_reset_flags got=%b exp=00000", {wp0, h0, wp1, h1, tc1}); end
    m_q = 0; m_wp = 0; m_h = 0;
    #2 reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 4'd9);
    e = sb.pop_front();
    checks++; if (q0 !== e.q || q1 !== 4'd0) begin failures++; $display("FAIL resume got=%0d/%0d exp=%0d/0", q0, q1, e.q); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_oneshot();
    test_priority();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
